// File: rtl/byte_fifo_if.sv
// Byte stream handshake bundle for byte_fifo: write side and read side.
// slave is the FIFO view; master is the producer/consumer view.
interface byte_fifo_if;
   logic [7:0] in_data_i;
   logic       in_valid_i;
   logic       in_ready_o;
   logic [7:0] out_data_o;
   logic       out_valid_o;
   logic       out_ready_i;

   modport slave (
      input  in_data_i,
      input  in_valid_i,
      output in_ready_o,
      output out_data_o,
      output out_valid_o,
      input  out_ready_i
   );

   modport master (
      output in_data_i,
      output in_valid_i,
      input  in_ready_o,
      input  out_data_o,
      input  out_valid_o,
      output out_ready_i
   );
endinterface

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO with level, almost-full, overflow, flush.
// Define BYTE_FIFO_WM_IRQ_EN to add the wm_irq_o watermark pulse output.
module byte_fifo #(
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = 12
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   byte_fifo_if.slave             bus,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   almost_full_o,
   output logic                   overflow_o
`ifdef BYTE_FIFO_WM_IRQ_EN
   ,
   output logic                   wm_irq_o
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] THR = (AW+1)'(AFULL_THRESH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_q;
   logic [AW:0] rd_q;
   logic        ovf_q;
   logic        clr;
   logic        empty;
   logic        full;
   logic        push;
   logic        pop;

   assign clr   = rst_i | flush_i;
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) &&
                  (wr_q[AW] != rd_q[AW]);

   assign push = bus.in_valid_i & ~full;
   assign pop  = bus.out_ready_i & ~empty;

   assign bus.in_ready_o  = ~full;
   assign bus.out_valid_o = ~empty;
   assign bus.out_data_o  = mem[rd_q[AW-1:0]];

   // Wrap-bit pointers make the difference an exact 0..DEPTH count.
   assign level_o       = wr_q - rd_q;
   assign almost_full_o = (level_o >= THR);
   assign overflow_o    = ovf_q;

   always_ff @(posedge clk_i) begin
      if (clr) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (push)
            wr_q <= wr_q + 1'b1;
         if (pop)
            rd_q <= rd_q + 1'b1;
         if (bus.in_valid_i & full)
            ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push & ~clr)
         mem[wr_q[AW-1:0]] <= bus.in_data_i;
   end

`ifdef BYTE_FIFO_WM_IRQ_EN
   logic af_d;
   logic irq_q;

   // Rising edge of almost_full, seen one cycle late; clear kills it.
   always_ff @(posedge clk_i) begin
      if (clr) begin
         af_d  <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         af_d  <= almost_full_o;
         irq_q <= almost_full_o & ~af_d;
      end
   end

   assign wm_irq_o = irq_q;
`endif

endmodule

// File: doc/byte_fifo.md
Name: byte_fifo

Overview:
- Parameterised first-word-fall-through byte FIFO with valid/ready handshakes on both sides.
- Sits between the USB_CDC OUT endpoint and the MCU interface block's out_data/out_valid/out_ready port, so host bursts are absorbed while the MCU drains bytes one at a time.
- A second instance sits on the IN path, between the interface block's in_data/in_valid/in_ready and USB_CDC.
- Provides occupancy level, almost-full flag and synchronous flush.

Parameters:
- DEPTH, 16: number of byte entries; power of 2, minimum 2.
- AFULL_THRESH, 12: almost_full_o asserts when level >= AFULL_THRESH; valid range 1..DEPTH.

Ports:
- clk_i, input, 1: clock; all state updates on its rising edge.
- rst_i, input, 1: reset, synchronous, active-high.
- flush_i, input, 1: synchronous clear of contents, one-cycle pulse or level.
- in_data_i, input, 8: write data.
- in_valid_i, input, 1: write request; in_data_i valid while high.
- in_ready_o, output, 1: FIFO can accept a byte; push occurs when in_valid_i and in_ready_o are both high.
- out_data_o, output, 8: head byte; stable while out_valid_o is high and not popped.
- out_valid_o, output, 1: head byte available.
- out_ready_i, input, 1: consumer accepts; pop occurs when out_valid_o and out_ready_i are both high.
- level_o, output, clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- almost_full_o, output, 1: level_o >= AFULL_THRESH.
- overflow_o, output, 1: sticky; set when in_valid_i is high while in_ready_o is low; cleared by reset or flush.

Behaviour:
- Storage: DEPTH x 8 register array, no RAM inference requirement.
  - Read and write pointers are clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Empty when pointers are fully equal.
  - Full when the low bits are equal and the MSBs differ.
- All outputs are registered or decoded directly from registers. There are no combinational paths from in_valid_i/out_ready_i to in_ready_o/out_valid_o.
- Reset (rst_i high at a clock edge), synchronous, highest priority:
  - pointers = 0, level_o = 0, out_valid_o = 0, in_ready_o = 1, almost_full_o = 0, overflow_o = 0.
  - out_data_o reads entry 0; its value is don't-care while out_valid_o is low.
  - Array contents are not reset.
- Push: in_valid_i & in_ready_o → mem[wr_ptr] <= in_data_i, wr_ptr += 1.
- Pop: out_valid_o & out_ready_i → rd_ptr += 1.
- out_data_o = mem[rd_ptr low bits]; out_valid_o = not empty.
- Latency: a byte pushed into an empty FIFO at edge N is visible with out_valid_o = 1 after edge N; it can be popped at edge N+1.
- in_ready_o = not full.
  - When full, in_ready_o stays 0 even in a cycle where a pop occurs.
  - Space reappears the cycle after the pop.
- Simultaneous push and pop: both occur, level unchanged.
  - Includes level 1, where the new byte becomes head after the edge.
- Level 0 with push and no pop: level goes to 1. A pop cannot occur at level 0 since out_valid_o = 0.
- level_o: +1 on push only, −1 on pop only, unchanged on both or neither. Saturation is impossible by construction.
- almost_full_o is updated in the same cycle as level_o and consistent with it.
- Pointer wrap: low bits roll from DEPTH−1 to 0 and the MSB toggles. Data order is preserved across wrap.
- Flush (flush_i high, rst_i low):
  - Same effect as reset on pointers, level_o, flags and overflow_o.
  - A push or pop in the same cycle is ignored; the pushed byte is dropped.
- Reset or flush mid-burst: the FIFO is empty the next cycle. There is no partial state.

Optional Feature:
- Macro: BYTE_FIFO_WM_IRQ_EN.
- When defined:
  - Adds output wm_irq_o (1 bit, reset 0).
  - wm_irq_o is a one-cycle pulse in the cycle after level_o transitions from below AFULL_THRESH to >= AFULL_THRESH.
  - No pulse on flush or reset; re-arms only after level drops below the threshold.
- When undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Fill/drain: after reset, push 0x01..0x10 back-to-back with out_ready_i = 0.
  - Required: in_ready_o low after the 16th push; level_o = 16; almost_full_o high from level 12.
  - Then out_ready_i = 1: bytes 0x01..0x10 pop in order, out_valid_o low after the last one.
- FWFT latency: empty FIFO, push 0xA5 at edge N.
  - Required: out_valid_o = 1 and out_data_o = 0xA5 after edge N; level_o = 1.
- Full + pop + push: with the FIFO full, assert in_valid_i = 1 with 0x77 and out_ready_i = 1.
  - Required: one pop, 0x77 not accepted, overflow_o set.
  - Next cycle in_ready_o = 1; pushing 0x77 then succeeds and it exits 16th.
- Wrap: 40 iterations of push then pop with level held at 3, random data.
  - Required: output sequence equals input sequence; pointers wrap twice without error.
- Flush mid-burst: level 9, assert flush_i together with a push of 0x55.
  - Required: next cycle level_o = 0, out_valid_o = 0, overflow_o = 0; 0x55 never emerges.
- Watermark (BYTE_FIFO_WM_IRQ_EN defined): push to 12.
  - Required: exactly one wm_irq_o pulse.
  - Pop to 11 and push to 12: second pulse; holding at 12 or 13 produces no extra pulse.
